// File: rtl/dsp_bus_pkg.sv
// rtl/dsp_bus_pkg.sv - shared state encodings, fault codes and bus widths for the DSP bus qualifier
package dsp_bus_pkg;

  localparam int AB_W_DEF = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_QUAL_RD  = 3'd1,
    ST_QUAL_WR  = 3'd2,
    ST_HOLD     = 3'd3,
    ST_CONFLICT = 3'd4,
    ST_RECOVER  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_CONFLICT = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchroniser with selectable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dsp_bus_cycle_qualifier.sv
// rtl/dsp_bus_cycle_qualifier.sv - qualifies raw DSP ~RE/~WE into one-cycle rd/wr strobes with captured address
module dsp_bus_cycle_qualifier
  import dsp_bus_pkg::*;
#(
  parameter int AB_W       = AB_W_DEF,
  parameter int DEB_CYCLES = 2,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 8
) (
  input  logic             clkDspIn,
  input  logic             dsp_reset,
  input  logic             re,
  input  logic             we,
  input  logic [AB_W-1:0]  ab,
  input  logic             err_clr,
  output logic             rd_strobe,
  output logic             wr_strobe,
  output logic [AB_W-1:0]  strobe_addr,
  output logic             bus_active,
  output logic             bus_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic re_s, we_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_re (.clk(clkDspIn), .rst_n(dsp_reset), .d(re), .q(re_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_we (.clk(clkDspIn), .rst_n(dsp_reset), .d(we), .q(we_s));

  state_t            state_q, state_d;
  logic [AB_W-1:0]   ab_q, ab_qq, addr_c_q, addr_c_d, strobe_addr_q, strobe_addr_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              is_wr_q, is_wr_d;
  logic              fire_rd_q, fire_rd_d, fire_wr_q, fire_wr_d;
  logic              rd_strobe_q, rd_strobe_d, wr_strobe_q, wr_strobe_d;
  logic              bus_active_q, bus_active_d, bus_err_q, bus_err_d;
  logic [1:0]        err_q, err_d, err_set;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic              own_s, other_s;

  // The qualify decision is made one edge before the strobe is driven, so the
  // strobe, its address and the count all change together on a clean register.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_c_d      = addr_c_q;
    is_wr_d       = is_wr_q;
    tmo_d         = tmo_q;
    fire_rd_d     = 1'b0;
    fire_wr_d     = 1'b0;
    err_set       = ERR_NONE;
    own_s         = (state_q == ST_QUAL_WR) ? we_s : re_s;
    other_s       = (state_q == ST_QUAL_WR) ? re_s : we_s;
    rd_strobe_d   = fire_rd_q;
    wr_strobe_d   = fire_wr_q;
    strobe_addr_d = (fire_rd_q || fire_wr_q) ? addr_c_q : strobe_addr_q;
    cycle_count_d = (fire_rd_q || fire_wr_q) ? cycle_count_q + CNT_W'(1) : cycle_count_q;

    case (state_q)
      ST_IDLE: begin
        if (!re_s && !we_s) begin
          state_d = ST_CONFLICT;
          err_set = ERR_CONFLICT;
        end else if (!re_s || !we_s) begin
          state_d  = !re_s ? ST_QUAL_RD : ST_QUAL_WR;
          is_wr_d  = re_s;
          cnt_d    = DEB_W'(1);
          addr_c_d = ab_qq;
        end
      end
      ST_QUAL_RD, ST_QUAL_WR: begin
        if (own_s) begin
          state_d = ST_IDLE;
        end else if (!other_s) begin
          state_d = ST_CONFLICT;
          err_set = ERR_CONFLICT;
        end else if (ab_qq != addr_c_q) begin
          cnt_d    = DEB_W'(1);
          addr_c_d = ab_qq;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = ST_HOLD;
          tmo_d     = '0;
          fire_rd_d = !is_wr_q;
          fire_wr_d = is_wr_q;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
      ST_HOLD: begin
        if (re_s && we_s) begin
          state_d = ST_RECOVER;
        end else begin
          // Saturating at TIMEOUT keeps the fault from re-arming after err_clr.
          if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_LAST) err_set = err_set | ERR_TIMEOUT;
          if (is_wr_q ? !re_s : !we_s) err_set = err_set | ERR_CONFLICT;
        end
      end
      ST_CONFLICT: begin
        if (re_s && we_s) state_d = ST_RECOVER;
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    bus_active_d = (state_d == ST_QUAL_RD) || (state_d == ST_QUAL_WR) || (state_d == ST_HOLD);
    err_d        = (err_clr ? ERR_NONE : err_q) | err_set;
    bus_err_d    = |err_d;
  end

  always_ff @(posedge clkDspIn or negedge dsp_reset) begin
    if (!dsp_reset) begin
      state_q       <= ST_IDLE;
      ab_q          <= '0;
      ab_qq         <= '0;
      addr_c_q      <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      is_wr_q       <= 1'b0;
      fire_rd_q     <= 1'b0;
      fire_wr_q     <= 1'b0;
      rd_strobe_q   <= 1'b0;
      wr_strobe_q   <= 1'b0;
      strobe_addr_q <= '0;
      bus_active_q  <= 1'b0;
      bus_err_q     <= 1'b0;
      err_q         <= ERR_NONE;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ab_q          <= ab;
      ab_qq         <= ab_q;
      addr_c_q      <= addr_c_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      is_wr_q       <= is_wr_d;
      fire_rd_q     <= fire_rd_d;
      fire_wr_q     <= fire_wr_d;
      rd_strobe_q   <= rd_strobe_d;
      wr_strobe_q   <= wr_strobe_d;
      strobe_addr_q <= strobe_addr_d;
      bus_active_q  <= bus_active_d;
      bus_err_q     <= bus_err_d;
      err_q         <= err_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign rd_strobe   = rd_strobe_q;
  assign wr_strobe   = wr_strobe_q;
  assign strobe_addr = strobe_addr_q;
  assign bus_active  = bus_active_q;
  assign bus_err     = bus_err_q;
  assign err_code    = err_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_dsp_bus_cycle_qualifier.sv
// tb/tb_dsp_bus_cycle_qualifier.sv - directed self-checking bench for dsp_bus_cycle_qualifier
module tb_dsp_bus_cycle_qualifier;

  logic        clkDspIn = 1'b0;
  logic        dsp_reset;
  logic        re, we, err_clr;
  logic [10:0] ab;
  logic        rd_strobe, wr_strobe, bus_active, bus_err;
  logic [10:0] strobe_addr;
  logic [1:0]  err_code;
  logic [7:0]  cycle_count;

  int checks = 0;
  int failures = 0;
  int tick, rd_cnt, wr_cnt, first_rd, first_wr, both_cnt;

  always #5 clkDspIn = ~clkDspIn;

  dsp_bus_cycle_qualifier dut (
    .clkDspIn(clkDspIn), .dsp_reset(dsp_reset), .re(re), .we(we), .ab(ab),
    .err_clr(err_clr), .rd_strobe(rd_strobe), .wr_strobe(wr_strobe),
    .strobe_addr(strobe_addr), .bus_active(bus_active), .bus_err(bus_err),
    .err_code(err_code), .cycle_count(cycle_count)
  );

  task automatic clr_mon();
    tick = 0; rd_cnt = 0; wr_cnt = 0; first_rd = -1; first_wr = -1; both_cnt = 0;
  endtask

  // One clock: sample 1 time unit after the rising edge and tally strobe pulses.
  task automatic step();
    @(posedge clkDspIn); #1;
    tick++;
    if (rd_strobe) begin rd_cnt++; if (first_rd < 0) first_rd = tick; end
    if (wr_strobe) begin wr_cnt++; if (first_wr < 0) first_wr = tick; end
    if (rd_strobe && wr_strobe) both_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    dsp_reset = 1'b1; re = 1'b1; we = 1'b1; ab = '0; err_clr = 1'b0;
    #3 dsp_reset = 1'b0;
    #1;
    checks++; if (rd_strobe !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", rd_strobe); end
    checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", wr_strobe); end
    checks++; if (bus_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", bus_active); end
    checks++; if (bus_err !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL reset_err got=%b/%b exp=0/00", bus_err, err_code); end
    checks++; if (strobe_addr !== 11'h000 || cycle_count !== 8'd0) begin failures++; $display("FAIL reset_addr_cnt got=%h/%0d exp=000/0", strobe_addr, cycle_count); end
    run(2);
    dsp_reset = 1'b1;
    run(3);
  endtask

  task automatic test_read();
    clr_mon();
    ab = 11'h005; re = 1'b0;
    run(8);
    re = 1'b1;
    run(8);
    checks++; if (rd_cnt !== 1 || wr_cnt !== 0) begin failures++; $display("FAIL read_count got rd=%0d wr=%0d exp rd=1 wr=0", rd_cnt, wr_cnt); end
    checks++; if (first_rd !== 6) begin failures++; $display("FAIL read_latency got=%0d exp=6", first_rd); end
    checks++; if (strobe_addr !== 11'h005) begin failures++; $display("FAIL read_addr got=%h exp=005", strobe_addr); end
    checks++; if (cycle_count !== 8'd1) begin failures++; $display("FAIL read_cycle_count got=%0d exp=1", cycle_count); end
    checks++; if (bus_err !== 1'b0 || bus_active !== 1'b0) begin failures++; $display("FAIL read_idle got err=%b active=%b exp 0/0", bus_err, bus_active); end
  endtask

  task automatic test_glitch();
    clr_mon();
    we = 1'b0;
    run(1);
    we = 1'b1;
    run(10);
    checks++; if (wr_cnt !== 0 || rd_cnt !== 0) begin failures++; $display("FAIL glitch_strobe got rd=%0d wr=%0d exp 0/0", rd_cnt, wr_cnt); end
    checks++; if (bus_err !== 1'b0 || bus_active !== 1'b0) begin failures++; $display("FAIL glitch_state got err=%b active=%b exp 0/0", bus_err, bus_active); end
    checks++; if (cycle_count !== 8'd1) begin failures++; $display("FAIL glitch_cycle_count got=%0d exp=1", cycle_count); end
  endtask

  task automatic test_addr_change();
    clr_mon();
    ab = 11'h001; we = 1'b0;
    run(1);
    ab = 11'h002;
    run(9);
    we = 1'b1;
    run(6);
    checks++; if (wr_cnt !== 1 || rd_cnt !== 0) begin failures++; $display("FAIL addr_count got rd=%0d wr=%0d exp rd=0 wr=1", rd_cnt, wr_cnt); end
    checks++; if (first_wr !== 7) begin failures++; $display("FAIL addr_restart_latency got=%0d exp=7", first_wr); end
    checks++; if (strobe_addr !== 11'h002) begin failures++; $display("FAIL addr_value got=%h exp=002", strobe_addr); end
    checks++; if (cycle_count !== 8'd2) begin failures++; $display("FAIL addr_cycle_count got=%0d exp=2", cycle_count); end
  endtask

  task automatic test_conflict();
    clr_mon();
    re = 1'b0; we = 1'b0;
    run(4);
    re = 1'b1; we = 1'b1;
    run(6);
    checks++; if (rd_cnt !== 0 || wr_cnt !== 0) begin failures++; $display("FAIL conflict_strobe got rd=%0d wr=%0d exp 0/0", rd_cnt, wr_cnt); end
    checks++; if (bus_err !== 1'b1 || err_code !== 2'b01) begin failures++; $display("FAIL conflict_err got=%b/%b exp=1/01", bus_err, err_code); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if (bus_err !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL conflict_clear got=%b/%b exp=0/00", bus_err, err_code); end
    // err_clr lands on the same edge the conflict is flagged: the new fault must survive
    re = 1'b0; we = 1'b0;
    run(2);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if (err_code !== 2'b01) begin failures++; $display("FAIL conflict_set_wins got=%b exp=01", err_code); end
    re = 1'b1; we = 1'b1;
    run(6);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if (err_code !== 2'b00 || bus_active !== 1'b0) begin failures++; $display("FAIL conflict_exit got code=%b active=%b exp 00/0", err_code, bus_active); end
  endtask

  task automatic test_timeout();
    clr_mon();
    ab = 11'h7FF; re = 1'b0;
    run(68);
    checks++; if (err_code !== 2'b00) begin failures++; $display("FAIL timeout_early got=%b exp=00", err_code); end
    checks++; if (rd_cnt !== 1 || first_rd !== 6) begin failures++; $display("FAIL timeout_strobe got n=%0d at=%0d exp n=1 at=6", rd_cnt, first_rd); end
    run(1);
    checks++; if (err_code !== 2'b10 || bus_err !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%b/%b exp=10/1", err_code, bus_err); end
    run(11);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    run(20);
    checks++; if (err_code !== 2'b00 || bus_active !== 1'b1) begin failures++; $display("FAIL timeout_once got code=%b active=%b exp 00/1", err_code, bus_active); end
    re = 1'b1;
    run(6);
    checks++; if (bus_active !== 1'b0 || rd_cnt !== 1) begin failures++; $display("FAIL timeout_release got active=%b rd=%0d exp 0/1", bus_active, rd_cnt); end
    checks++; if (strobe_addr !== 11'h7FF || cycle_count !== 8'd3) begin failures++; $display("FAIL timeout_addr_cnt got=%h/%0d exp=7ff/3", strobe_addr, cycle_count); end
  endtask

  task automatic test_reset_mid_and_wrap();
    clr_mon();
    ab = 11'h0A5; we = 1'b0;
    run(3);
    checks++; if (bus_active !== 1'b1) begin failures++; $display("FAIL midreset_pre got active=%b exp=1", bus_active); end
    dsp_reset = 1'b0;
    #2;
    checks++; if (bus_active !== 1'b0 || wr_strobe !== 1'b0) begin failures++; $display("FAIL midreset_async got active=%b wr=%b exp 0/0", bus_active, wr_strobe); end
    checks++; if (cycle_count !== 8'd0 || strobe_addr !== 11'h000) begin failures++; $display("FAIL midreset_regs got=%0d/%h exp=0/000", cycle_count, strobe_addr); end
    run(2);
    dsp_reset = 1'b1;
    clr_mon();
    run(10);
    we = 1'b1;
    run(6);
    checks++; if (wr_cnt !== 1 || first_wr !== 6) begin failures++; $display("FAIL midreset_requal got n=%0d at=%0d exp n=1 at=6", wr_cnt, first_wr); end
    checks++; if (cycle_count !== 8'd1 || strobe_addr !== 11'h0A5) begin failures++; $display("FAIL midreset_count got=%0d/%h exp=1/0a5", cycle_count, strobe_addr); end
    clr_mon();
    for (int i = 0; i < 255; i++) begin
      ab = 11'(i);
      if (i[0]) we = 1'b0; else re = 1'b0;
      run(6);
      re = 1'b1; we = 1'b1;
      run(4);
      if (i == 253) begin
        checks++; if (cycle_count !== 8'd255) begin failures++; $display("FAIL wrap_pre got=%0d exp=255", cycle_count); end
      end
    end
    checks++; if (cycle_count !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", cycle_count); end
    checks++; if (rd_cnt !== 128 || wr_cnt !== 127) begin failures++; $display("FAIL wrap_pulses got rd=%0d wr=%0d exp rd=128 wr=127", rd_cnt, wr_cnt); end
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL wrap_exclusive got=%0d exp=0", both_cnt); end
    checks++; if (strobe_addr !== 11'd254) begin failures++; $display("FAIL wrap_addr got=%0d exp=254", strobe_addr); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_glitch();
    test_addr_change();
    test_conflict();
    test_timeout();
    test_reset_mid_and_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
